dmem_sram_ctrl: RTL

Data-memory responder at the far end of the MEM-stage RAM request interface. Accepts one word/byte/halfword load or store per request from `mem`, runs it against an external asynchronous SRAM with a fixed number of wait states, and holds `stallreq` high until the access completes. On the completion cycle it returns read data to `mem`. Sits between `mem` and the board SRAM pins; the pipeline control unit ORs its `stallreq` into the global stall.

---
 rtl/dmem_sram_ctrl_pkg.sv | 30 +++
 rtl/dmem_sram_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dmem_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sram_ctrl_pkg
// Description : Shared types and constants for the data-memory SRAM
//               controller: FSM state codes, bus word type, idle levels.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_sram_ctrl_pkg;

    localparam int REG_BUS_W = 32;

    typedef logic [REG_BUS_W-1:0] reg_bus_t;

    localparam reg_bus_t ZERO_WORD = '0;

    // FSM state encoding
    typedef logic [1:0] dmem_state_t;

    localparam dmem_state_t DMEM_IDLE   = 2'd0;
    localparam dmem_state_t DMEM_ACCESS = 2'd1;
    localparam dmem_state_t DMEM_DONE   = 2'd2;

    // Inactive level of the active-low SRAM control strobes
    localparam logic SRAM_CTRL_DISABLE = 1'b1;

    // Wait-state counter width: covers WAIT_CYCLES up to 15
    localparam int CNT_W = 4;

endpackage : dmem_sram_ctrl_pkg
`default_nettype wire

// File: rtl/dmem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sram_ctrl
// Description : MEM-stage data-memory responder. Captures one load/store
//               request, runs it against an asynchronous SRAM for a fixed
//               number of wait states, stalls the pipeline meanwhile and
//               returns the read word in the completion (DONE) cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_sram_ctrl
    import dmem_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,

    // MEM-stage request interface
    input  logic              mem_ce_i,
    input  logic              mem_wr_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [3:0]        mem_we_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       mem_data_o,
    output logic              stallreq,

    // SRAM pins
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    // Counter preload: ACCESS lasts exactly WAIT_CYCLES cycles
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    dmem_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic               wr_q,    wr_d;
    logic [3:0]         be_q,    be_d;
    reg_bus_t           wdata_q, wdata_d;
    reg_bus_t           rdata_q, rdata_d;

    // Byte-offset bits and bits above the SRAM size are don't-care
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    // State, counter and request/response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= ZERO_WORD;
            rdata_q <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state: capture in IDLE, count wait states in ACCESS, one DONE cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            DMEM_IDLE: begin
                if (mem_ce_i) begin
                    addr_d  = mem_addr_i[ADDR_W+1:2];
                    wr_d    = mem_wr_i;
                    be_d    = mem_we_i;
                    wdata_d = mem_data_i;
                    cnt_d   = C_CNT_LOAD;
                    state_d = DMEM_ACCESS;
                end
            end
            DMEM_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DMEM_DONE;
                    if (!wr_q) begin
                        rdata_d = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DMEM_DONE: begin
                // The request still visible here is the one just served
                state_d = DMEM_IDLE;
            end
            default: begin
                state_d = DMEM_IDLE;
            end
        endcase
    end

    // SRAM strobes and stall request decoded from the current state
    always_comb begin
        sram_ce_n  = SRAM_CTRL_DISABLE;
        sram_oe_n  = SRAM_CTRL_DISABLE;
        sram_we_n  = SRAM_CTRL_DISABLE;
        sram_be_n  = 4'b1111;
        sram_addr  = '0;
        sram_wdata = ZERO_WORD;
        stallreq   = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                stallreq = mem_ce_i;
            end
            DMEM_ACCESS: begin
                stallreq   = 1'b1;
                sram_ce_n  = 1'b0;
                sram_be_n  = ~be_q;
                sram_addr  = addr_q;
                sram_wdata = wdata_q;
                if (wr_q) begin
                    // A store with no lanes enabled never strobes the SRAM
                    sram_we_n = (be_q == 4'b0000);
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            DMEM_DONE: begin
                // Chip select, address, data and lanes held for write hold time
                sram_ce_n  = 1'b0;
                sram_be_n  = ~be_q;
                sram_addr  = addr_q;
                sram_wdata = wdata_q;
            end
            default: begin
                stallreq = 1'b0;
            end
        endcase
    end

    assign mem_data_o = rdata_q;

endmodule : dmem_sram_ctrl
`default_nettype wire
